// File: rtl/extbus_pkg.sv
// Shared types and register map for the external SRAM bus controller.
package extbus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CPU_ACC,
    ST_DMA_ACC,
    ST_DONE
  } state_t;

  localparam logic [3:0] REG_PAGE0  = 4'd0;
  localparam logic [3:0] REG_PAGE1  = 4'd1;
  localparam logic [3:0] REG_PAGE2  = 4'd2;
  localparam logic [3:0] REG_PAGE3  = 4'd3;
  localparam logic [3:0] REG_PAGE4  = 4'd4;
  localparam logic [3:0] REG_PAGE5  = 4'd5;
  localparam logic [3:0] REG_PAGE6  = 4'd6;
  localparam logic [3:0] REG_PAGE7  = 4'd7;
  localparam logic [3:0] REG_CTRL   = 4'd8;
  localparam logic [3:0] REG_STATUS = 4'd9;

  localparam int PAGE_WP_BIT   = 7;
  localparam int CTRL_MAP_EN   = 0;
  localparam int CTRL_IRQ_EN   = 1;
  localparam int CTRL_WAIT_LSB = 4;
  localparam int STAT_WP_FAULT = 0;
  localparam int STAT_DMA_BUSY = 1;

  // Page field covers the SRAM address bits above the 8 KB window offset.
  function automatic int page_width(input int ext_aw);
    return ext_aw - 13;
  endfunction

endpackage

// File: rtl/extbus_if.sv
// CPU, VPU-DMA, register-block and SRAM pin bundle of the external bus controller.
interface extbus_if #(
  parameter int EXT_AW = 19
);
  logic              cpu_req;
  logic              cpu_rw;
  logic [15:0]       cpu_addr;
  logic [7:0]        cpu_wdata;
  logic [7:0]        cpu_rdata;
  logic              cpu_hold;
  logic              dma_req;
  logic [15:0]       dma_addr;
  logic              dma_ack;
  logic [7:0]        dma_rdata;
  logic              reg_cs;
  logic              reg_rw;
  logic [3:0]        reg_ad;
  logic [7:0]        reg_di;
  logic [7:0]        reg_do;
  logic              irq;
  logic [EXT_AW-1:0] ext_addr;
  logic [7:0]        ext_dq_out;
  logic              ext_dq_oe;
  logic [7:0]        ext_dq_in;
  logic              ext_cs;
  logic              ext_oe_n;
  logic              ext_we_n;

  modport slave (
    input  cpu_req, cpu_rw, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_hold,
    input  dma_req, dma_addr,
    output dma_ack, dma_rdata,
    input  reg_cs, reg_rw, reg_ad, reg_di,
    output reg_do, irq,
    output ext_addr, ext_dq_out, ext_dq_oe, ext_cs, ext_oe_n, ext_we_n,
    input  ext_dq_in
  );

  modport master (
    output cpu_req, cpu_rw, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_hold,
    output dma_req, dma_addr,
    input  dma_ack, dma_rdata,
    output reg_cs, reg_rw, reg_ad, reg_di,
    input  reg_do, irq,
    input  ext_addr, ext_dq_out, ext_dq_oe, ext_cs, ext_oe_n, ext_we_n,
    output ext_dq_in
  );
endinterface

// File: rtl/extbus_map.sv
// Page/CTRL/STATUS register file with combinational window translation and
// write-protect lookup for the CPU address.
module extbus_map
  import extbus_pkg::*;
#(
  parameter int         EXT_AW      = 19,
  parameter logic [7:0] WIN_MASK    = 8'b01110000,
  parameter int         WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reg_cs,
  input  logic              reg_rw,
  input  logic [3:0]        reg_ad,
  input  logic [7:0]        reg_di,
  output logic [7:0]        reg_do,
  input  logic [15:0]       cpu_addr,
  output logic [EXT_AW-1:0] map_addr,
  output logic              map_wp,
  output logic [3:0]        wait_cnt,
  input  logic              set_fault,
  input  logic              dma_busy,
  output logic              irq
);

  localparam int PAGE_W = page_width(EXT_AW);

  logic [PAGE_W-1:0] page_q [8];
  logic [7:0]        wp_q;
  logic              map_en;
  logic              irq_en;
  logic              wp_fault;
  logic              reg_wr;
  logic [2:0]        slot;

  assign reg_wr = reg_cs & ~reg_rw;
  assign slot   = cpu_addr[15:13];
  assign irq    = wp_fault & irq_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 8; i++) page_q[i] <= '0;
      wp_q     <= '0;
      map_en   <= 1'b0;
      irq_en   <= 1'b0;
      wait_cnt <= 4'(WAIT_STATES);
      wp_fault <= 1'b0;
    end else begin
      if (reg_wr && reg_ad <= REG_PAGE7) begin
        page_q[reg_ad[2:0]] <= reg_di[PAGE_W-1:0];
        wp_q[reg_ad[2:0]]   <= reg_di[PAGE_WP_BIT];
      end
      if (reg_wr && reg_ad == REG_CTRL) begin
        map_en   <= reg_di[CTRL_MAP_EN];
        irq_en   <= reg_di[CTRL_IRQ_EN];
        wait_cnt <= reg_di[CTRL_WAIT_LSB +: 4];
      end
      // A fault raised in the same cycle as a clear-write must not be lost.
      if (set_fault) begin
        wp_fault <= 1'b1;
      end else if (reg_wr && reg_ad == REG_STATUS && reg_di[STAT_WP_FAULT]) begin
        wp_fault <= 1'b0;
      end
    end
  end

  always_comb begin
    reg_do = 8'hFF;
    if (reg_ad <= REG_PAGE7) begin
      reg_do                = '0;
      reg_do[PAGE_WP_BIT]   = wp_q[reg_ad[2:0]];
      reg_do[PAGE_W-1:0]    = page_q[reg_ad[2:0]];
    end else if (reg_ad == REG_CTRL) begin
      reg_do                       = '0;
      reg_do[CTRL_MAP_EN]          = map_en;
      reg_do[CTRL_IRQ_EN]          = irq_en;
      reg_do[CTRL_WAIT_LSB +: 4]   = wait_cnt;
    end else if (reg_ad == REG_STATUS) begin
      reg_do                = '0;
      reg_do[STAT_WP_FAULT] = wp_fault;
      reg_do[STAT_DMA_BUSY] = dma_busy;
    end
  end

  always_comb begin
    map_addr = {{(EXT_AW-16){1'b0}}, cpu_addr};
    map_wp   = 1'b0;
    if (map_en && WIN_MASK[slot]) begin
      map_addr = {page_q[slot], cpu_addr[12:0]};
      map_wp   = wp_q[slot];
    end
  end

endmodule

// File: rtl/extbus_ctrl.sv
// External SRAM bus controller: CPU/VPU-DMA arbitration, wait-state timing
// and SRAM pin drive, with window remapping delegated to extbus_map.
module extbus_ctrl
  import extbus_pkg::*;
#(
  parameter int         EXT_AW        = 19,
  parameter logic [7:0] WIN_MASK      = 8'b01110000,
  parameter int         WAIT_STATES   = 1,
  parameter int         DMA_MAX_BURST = 4
) (
  input logic     clk,
  input logic     rst,
  extbus_if.slave bus
);

  localparam logic [7:0] MAX_BURST = 8'(DMA_MAX_BURST);

  state_t            state_q, state_d;
  logic [7:0]        burst_cnt;
  logic [3:0]        cnt_q;
  logic [EXT_AW-1:0] addr_q;
  logic [7:0]        wdata_q;
  logic              rw_q;
  logic              wp_q;
  logic              first_q;
  logic              last_dma_q;
  logic [7:0]        cpu_rdata_q;
  logic [7:0]        dma_rdata_q;

  logic [EXT_AW-1:0] map_addr;
  logic              map_wp;
  logic [3:0]        wait_cnt;
  logic              grant_cpu;
  logic              grant_dma;
  logic              in_acc;
  logic              set_fault;

  extbus_map #(
    .EXT_AW      (EXT_AW),
    .WIN_MASK    (WIN_MASK),
    .WAIT_STATES (WAIT_STATES)
  ) u_map (
    .clk       (clk),
    .rst       (rst),
    .reg_cs    (bus.reg_cs),
    .reg_rw    (bus.reg_rw),
    .reg_ad    (bus.reg_ad),
    .reg_di    (bus.reg_di),
    .reg_do    (bus.reg_do),
    .cpu_addr  (bus.cpu_addr),
    .map_addr  (map_addr),
    .map_wp    (map_wp),
    .wait_cnt  (wait_cnt),
    .set_fault (set_fault),
    .dma_busy  (state_q == ST_DMA_ACC),
    .irq       (bus.irq)
  );

  always_comb begin
    state_d   = state_q;
    grant_cpu = 1'b0;
    grant_dma = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.dma_req && (!bus.cpu_req || burst_cnt < MAX_BURST)) begin
          grant_dma = 1'b1;
          state_d   = ST_DMA_ACC;
        end else if (bus.cpu_req) begin
          grant_cpu = 1'b1;
          state_d   = ST_CPU_ACC;
        end
      end
      ST_CPU_ACC, ST_DMA_ACC: begin
        if (cnt_q == 4'd0) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_acc    = (state_q == ST_CPU_ACC) || (state_q == ST_DMA_ACC);
  assign set_fault = (state_q == ST_DONE) && !last_dma_q && !rw_q && wp_q;

  always_comb begin
    bus.ext_cs     = in_acc;
    bus.ext_addr   = addr_q;
    bus.ext_dq_out = wdata_q;
    bus.ext_oe_n   = !(in_acc && rw_q);
    // The strobe skips the first access cycle so address/data settle first.
    bus.ext_dq_oe  = in_acc && !rw_q && !wp_q;
    bus.ext_we_n   = !(in_acc && !rw_q && !wp_q && !first_q);
    bus.dma_ack    = (state_q == ST_DONE) && last_dma_q;
    bus.cpu_hold   = bus.cpu_req && !((state_q == ST_DONE) && !last_dma_q);
    bus.cpu_rdata  = cpu_rdata_q;
    bus.dma_rdata  = dma_rdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      burst_cnt   <= '0;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rw_q        <= 1'b1;
      wp_q        <= 1'b0;
      first_q     <= 1'b0;
      last_dma_q  <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      first_q <= grant_cpu | grant_dma;
      if (state_q == ST_IDLE) begin
        if (!bus.cpu_req) begin
          burst_cnt <= '0;
        end else if (grant_dma && burst_cnt != MAX_BURST) begin
          burst_cnt <= burst_cnt + 8'd1;
        end else if (grant_cpu) begin
          burst_cnt <= '0;
        end
      end
      if (grant_dma) begin
        addr_q     <= {{(EXT_AW-16){1'b0}}, bus.dma_addr};
        rw_q       <= 1'b1;
        wp_q       <= 1'b0;
        cnt_q      <= wait_cnt;
        last_dma_q <= 1'b1;
      end else if (grant_cpu) begin
        addr_q     <= map_addr;
        rw_q       <= bus.cpu_rw;
        wdata_q    <= bus.cpu_wdata;
        wp_q       <= !bus.cpu_rw && map_wp;
        cnt_q      <= wait_cnt;
        last_dma_q <= 1'b0;
      end
      if (in_acc) begin
        if (cnt_q != 4'd0) begin
          cnt_q <= cnt_q - 4'd1;
        end else if (state_q == ST_DMA_ACC) begin
          dma_rdata_q <= bus.ext_dq_in;
        end else if (rw_q) begin
          cpu_rdata_q <= bus.ext_dq_in;
        end
      end
    end
  end

endmodule

// File: tb/tb_extbus_ctrl.sv
// Directed self-checking bench for extbus_ctrl; the SRAM returns addr[7:0]^8'h5A.
module tb_extbus_ctrl;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  extbus_if #(.EXT_AW(19)) bus ();

  extbus_ctrl #(
    .EXT_AW        (19),
    .WIN_MASK      (8'b01110000),
    .WAIT_STATES   (1),
    .DMA_MAX_BURST (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.ext_dq_in = bus.ext_addr[7:0] ^ 8'h5A;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic reg_write(input logic [3:0] ad, input logic [7:0] di);
    @(negedge clk);
    bus.reg_cs = 1'b1; bus.reg_rw = 1'b0; bus.reg_ad = ad; bus.reg_di = di;
    @(negedge clk);
    bus.reg_cs = 1'b0; bus.reg_rw = 1'b1;
  endtask

  task automatic test_reset();
    logic [7:0] exp_rd [4];
    logic [3:0] ads [4];
    rst = 1'b1;
    bus.cpu_req = 0; bus.cpu_rw = 1; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dma_req = 0; bus.dma_addr = '0;
    bus.reg_cs = 0; bus.reg_rw = 1; bus.reg_ad = '0; bus.reg_di = '0;
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.ext_cs !== 1'b0) begin n_bad++; $display("FAIL rst_cs: got %b want 0", bus.ext_cs); end
    n_cmp++; if (bus.ext_oe_n !== 1'b1) begin n_bad++; $display("FAIL rst_oe_n: got %b want 1", bus.ext_oe_n); end
    n_cmp++; if (bus.ext_we_n !== 1'b1) begin n_bad++; $display("FAIL rst_we_n: got %b want 1", bus.ext_we_n); end
    n_cmp++; if (bus.ext_dq_oe !== 1'b0) begin n_bad++; $display("FAIL rst_dq_oe: got %b want 0", bus.ext_dq_oe); end
    n_cmp++; if (bus.ext_addr !== 19'h0) begin n_bad++; $display("FAIL rst_addr: got %h want 0", bus.ext_addr); end
    n_cmp++; if (bus.cpu_rdata !== 8'h00) begin n_bad++; $display("FAIL rst_cpu_rdata: got %h want 00", bus.cpu_rdata); end
    n_cmp++; if (bus.dma_rdata !== 8'h00) begin n_bad++; $display("FAIL rst_dma_rdata: got %h want 00", bus.dma_rdata); end
    n_cmp++; if (bus.dma_ack !== 1'b0) begin n_bad++; $display("FAIL rst_dma_ack: got %b want 0", bus.dma_ack); end
    n_cmp++; if (bus.irq !== 1'b0) begin n_bad++; $display("FAIL rst_irq: got %b want 0", bus.irq); end
    ads = '{4'd8, 4'd9, 4'd6, 4'd12};
    exp_rd = '{8'h10, 8'h00, 8'h00, 8'hFF};
    bus.reg_cs = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.reg_ad = ads[i];
      #1;
      n_cmp++; if (bus.reg_do !== exp_rd[i]) begin n_bad++; $display("FAIL rst_reg%0d: got %h want %h", ads[i], bus.reg_do, exp_rd[i]); end
    end
    bus.reg_cs = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_cpu_read();
    @(negedge clk);
    bus.cpu_addr = 16'h2000; bus.cpu_rw = 1'b1; bus.cpu_req = 1'b1;
    #1;
    n_cmp++; if (bus.cpu_hold !== 1'b1) begin n_bad++; $display("FAIL rd_hold_c0: got %b want 1", bus.cpu_hold); end
    n_cmp++; if (bus.ext_cs !== 1'b0) begin n_bad++; $display("FAIL rd_cs_c0: got %b want 0", bus.ext_cs); end
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c <= 2) begin
        n_cmp++; if (bus.ext_cs !== 1'b1) begin n_bad++; $display("FAIL rd_cs_c%0d: got %b want 1", c, bus.ext_cs); end
        n_cmp++; if (bus.ext_oe_n !== 1'b0) begin n_bad++; $display("FAIL rd_oe_n_c%0d: got %b want 0", c, bus.ext_oe_n); end
        n_cmp++; if (bus.ext_addr !== 19'h02000) begin n_bad++; $display("FAIL rd_addr_c%0d: got %h want 02000", c, bus.ext_addr); end
        n_cmp++; if (bus.cpu_hold !== 1'b1) begin n_bad++; $display("FAIL rd_hold_c%0d: got %b want 1", c, bus.cpu_hold); end
      end else begin
        n_cmp++; if (bus.ext_cs !== 1'b0) begin n_bad++; $display("FAIL rd_cs_done: got %b want 0", bus.ext_cs); end
        n_cmp++; if (bus.ext_oe_n !== 1'b1) begin n_bad++; $display("FAIL rd_oe_n_done: got %b want 1", bus.ext_oe_n); end
        n_cmp++; if (bus.cpu_hold !== 1'b0) begin n_bad++; $display("FAIL rd_hold_done: got %b want 0", bus.cpu_hold); end
        n_cmp++; if (bus.cpu_rdata !== 8'h5A) begin n_bad++; $display("FAIL rd_data: got %h want 5a", bus.cpu_rdata); end
        bus.cpu_req = 1'b0;
      end
    end
  endtask

  task automatic test_cpu_write_mapped();
    logic exp_we;
    reg_write(4'd6, 8'h05);
    reg_write(4'd8, 8'h11);
    @(negedge clk);
    bus.cpu_addr = 16'hC123; bus.cpu_rw = 1'b0; bus.cpu_wdata = 8'hA5; bus.cpu_req = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      exp_we = (c == 2) ? 1'b0 : 1'b1;
      n_cmp++; if (bus.ext_we_n !== exp_we) begin n_bad++; $display("FAIL wr_we_n_c%0d: got %b want %b", c, bus.ext_we_n, exp_we); end
      if (c <= 2) begin
        n_cmp++; if (bus.ext_addr !== 19'h0A123) begin n_bad++; $display("FAIL wr_addr_c%0d: got %h want 0a123", c, bus.ext_addr); end
        n_cmp++; if (bus.ext_dq_oe !== 1'b1) begin n_bad++; $display("FAIL wr_dq_oe_c%0d: got %b want 1", c, bus.ext_dq_oe); end
        n_cmp++; if (bus.ext_dq_out !== 8'hA5) begin n_bad++; $display("FAIL wr_dq_c%0d: got %h want a5", c, bus.ext_dq_out); end
        n_cmp++; if (bus.ext_oe_n !== 1'b1) begin n_bad++; $display("FAIL wr_oe_n_c%0d: got %b want 1", c, bus.ext_oe_n); end
      end else begin
        n_cmp++; if (bus.ext_cs !== 1'b0) begin n_bad++; $display("FAIL wr_cs_done: got %b want 0", bus.ext_cs); end
        n_cmp++; if (bus.cpu_hold !== 1'b0) begin n_bad++; $display("FAIL wr_hold_done: got %b want 0", bus.cpu_hold); end
        bus.cpu_req = 1'b0;
      end
    end
  endtask

  task automatic test_write_protect();
    reg_write(4'd5, 8'h83);
    reg_write(4'd8, 8'h13);
    @(negedge clk);
    bus.cpu_addr = 16'hA000; bus.cpu_rw = 1'b0; bus.cpu_wdata = 8'h3C; bus.cpu_req = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      n_cmp++; if (bus.ext_we_n !== 1'b1) begin n_bad++; $display("FAIL wp_we_n_c%0d: got %b want 1", c, bus.ext_we_n); end
      n_cmp++; if (bus.ext_dq_oe !== 1'b0) begin n_bad++; $display("FAIL wp_dq_oe_c%0d: got %b want 0", c, bus.ext_dq_oe); end
      if (c <= 2) begin
        n_cmp++; if (bus.ext_addr !== 19'h06000) begin n_bad++; $display("FAIL wp_addr_c%0d: got %h want 06000", c, bus.ext_addr); end
      end else begin
        bus.cpu_req = 1'b0;
      end
    end
    @(negedge clk);
    bus.reg_cs = 1'b1; bus.reg_rw = 1'b1; bus.reg_ad = 4'd9;
    #1;
    n_cmp++; if (bus.reg_do !== 8'h01) begin n_bad++; $display("FAIL wp_status: got %h want 01", bus.reg_do); end
    n_cmp++; if (bus.irq !== 1'b1) begin n_bad++; $display("FAIL wp_irq_set: got %b want 1", bus.irq); end
    bus.reg_cs = 1'b0;
    reg_write(4'd9, 8'h01);
    #1;
    n_cmp++; if (bus.irq !== 1'b0) begin n_bad++; $display("FAIL wp_irq_clr: got %b want 0", bus.irq); end
  endtask

  task automatic test_arbitration();
    int n_ack;
    int cpu_done;
    int c;
    reg_write(4'd8, 8'h10);
    @(negedge clk);
    bus.dma_addr = 16'h1234; bus.cpu_addr = 16'h0177; bus.cpu_rw = 1'b1;
    bus.dma_req = 1'b1; bus.cpu_req = 1'b1;
    n_ack = 0; cpu_done = -1; c = 0;
    while (c < 40 && cpu_done < 0) begin
      @(negedge clk);
      c++;
      if (bus.dma_ack === 1'b1) begin
        n_cmp++; if (c !== 4 * n_ack + 3) begin n_bad++; $display("FAIL arb_ack%0d_cycle: got %0d want %0d", n_ack, c, 4 * n_ack + 3); end
        n_cmp++; if (bus.dma_rdata !== 8'h6E) begin n_bad++; $display("FAIL arb_dma_data: got %h want 6e", bus.dma_rdata); end
        n_ack++;
      end
      if (bus.cpu_hold === 1'b0) cpu_done = c;
    end
    bus.cpu_req = 1'b0;
    n_cmp++; if (cpu_done !== 19) begin n_bad++; $display("FAIL arb_cpu_done: got %0d want 19", cpu_done); end
    n_cmp++; if (n_ack !== 4) begin n_bad++; $display("FAIL arb_acks_before_cpu: got %0d want 4", n_ack); end
    n_cmp++; if (bus.cpu_rdata !== 8'h2D) begin n_bad++; $display("FAIL arb_cpu_data: got %h want 2d", bus.cpu_rdata); end
    while (c < 60 && bus.dma_ack !== 1'b1) begin
      @(negedge clk);
      c++;
    end
    n_cmp++; if (c !== 23) begin n_bad++; $display("FAIL arb_dma_after_cpu: got %0d want 23", c); end
    bus.dma_req = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int n_ack;
    int last;
    reg_write(4'd8, 8'h00);
    @(negedge clk);
    bus.dma_addr = 16'h00A5; bus.dma_req = 1'b1;
    bus.reg_cs = 1'b1; bus.reg_rw = 1'b1; bus.reg_ad = 4'd9;
    n_ack = 0; last = -1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) begin
        n_cmp++; if (bus.reg_do !== 8'h02) begin n_bad++; $display("FAIL b2b_status_busy: got %h want 02", bus.reg_do); end
      end
      if (bus.dma_ack === 1'b1) begin
        n_cmp++; if (c !== last + 3) begin n_bad++; $display("FAIL b2b_ack_cycle: got %0d want %0d", c, last + 3); end
        n_cmp++; if (bus.dma_rdata !== 8'hFF) begin n_bad++; $display("FAIL b2b_data: got %h want ff", bus.dma_rdata); end
        last = c;
        n_ack++;
      end
    end
    n_cmp++; if (n_ack !== 4) begin n_bad++; $display("FAIL b2b_ack_count: got %0d want 4", n_ack); end
    bus.dma_req = 1'b0; bus.reg_cs = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid_write();
    reg_write(4'd6, 8'h05);
    reg_write(4'd8, 8'h11);
    @(negedge clk);
    bus.cpu_addr = 16'hC000; bus.cpu_rw = 1'b0; bus.cpu_wdata = 8'h77; bus.cpu_req = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.ext_we_n !== 1'b0) begin n_bad++; $display("FAIL mid_we_active: got %b want 0", bus.ext_we_n); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (bus.ext_we_n !== 1'b1) begin n_bad++; $display("FAIL mid_we_n: got %b want 1", bus.ext_we_n); end
    n_cmp++; if (bus.ext_cs !== 1'b0) begin n_bad++; $display("FAIL mid_cs: got %b want 0", bus.ext_cs); end
    n_cmp++; if (bus.ext_dq_oe !== 1'b0) begin n_bad++; $display("FAIL mid_dq_oe: got %b want 0", bus.ext_dq_oe); end
    n_cmp++; if (bus.ext_addr !== 19'h0) begin n_bad++; $display("FAIL mid_addr: got %h want 0", bus.ext_addr); end
    bus.reg_cs = 1'b1; bus.reg_rw = 1'b1; bus.reg_ad = 4'd6;
    #1;
    n_cmp++; if (bus.reg_do !== 8'h00) begin n_bad++; $display("FAIL mid_page6: got %h want 00", bus.reg_do); end
    bus.reg_ad = 4'd8;
    #1;
    n_cmp++; if (bus.reg_do !== 8'h10) begin n_bad++; $display("FAIL mid_ctrl: got %h want 10", bus.reg_do); end
    bus.reg_cs = 1'b0; bus.cpu_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.ext_cs !== 1'b0) begin n_bad++; $display("FAIL mid_idle_after: got %b want 0", bus.ext_cs); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_cpu_read();
    test_cpu_write_mapped();
    test_write_protect();
    test_arbitration();
    test_back_to_back();
    test_reset_mid_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/extbus_ctrl.md
Name: extbus_ctrl

Overview:
- Parametrised external SRAM bus controller for the 6801 SoC.
- Replaces the fixed single-window page select and the free-running VPU/CPU sharing of the external bus.
- Arbitrates CPU and VPU-DMA accesses to one asynchronous SRAM port, with programmable wait states, N remappable 8 KB windows, per-window write protect and a fault interrupt.
- Sits between the CPU address decode (external-space request) and the SRAM pins.

Parameters:
- EXT_AW, 19, external SRAM address width; page field width PAGE_W = EXT_AW-13.
- WIN_MASK, 8'b01110000, bit i set = 8 KB slot i (cpu_addr[15:13]==i) is remappable.
- WAIT_STATES, 1, reset value of the wait-state count (0..15).
- DMA_MAX_BURST, 4, consecutive DMA grants allowed while the CPU waits.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: asynchronous reset, active-high.
- cpu_req, in, 1: CPU external access valid (external-space decode AND vma).
- cpu_rw, in, 1: 1 = read.
- cpu_addr, in, 16: CPU address.
- cpu_wdata, in, 8: CPU write data.
- cpu_rdata, out, 8: registered read data.
- cpu_hold, out, 1: stretch the CPU cycle.
- dma_req, in, 1: VPU read request (level).
- dma_addr, in, 16: VPU address, never translated.
- dma_ack, out, 1: one-cycle pulse; dma_rdata is valid in that cycle.
- dma_rdata, out, 8: DMA read data.
- reg_cs, in, 1: register block select.
- reg_rw, in, 1: register read/write.
- reg_ad, in, 4: register offset.
- reg_di, in, 8: register write data.
- reg_do, out, 8: register read data.
- irq, out, 1: wp_fault AND irq_en.
- ext_addr, out, EXT_AW: SRAM address.
- ext_dq_out, out, 8: SRAM write data.
- ext_dq_oe, out, 1: drive the data bus.
- ext_dq_in, in, 8: SRAM read data.
- ext_cs, out, 1: SRAM chip select.
- ext_oe_n, out, 1: SRAM output enable, active low.
- ext_we_n, out, 1: SRAM write enable, active low.

Behaviour:
- Reset (async, immediate, also mid-access):
  - FSM to IDLE; burst_cnt=0.
  - All page regs 0; map_en=0; irq_en=0; wait_cnt=WAIT_STATES; wp_fault=0.
  - ext_cs=0, ext_oe_n=1, ext_we_n=1, ext_dq_oe=0, ext_addr=0.
  - cpu_rdata=0, dma_rdata=0, dma_ack=0, irq=0.
- Registers: writes occur on the clk edge when reg_cs AND NOT reg_rw. Reads are combinational; unused bits read 0; offsets 10-15 read 8'hFF.
  - 0-7 PAGEi: bit7 = WP; [PAGE_W-1:0] = page.
  - 8 CTRL: bit0 map_en; bit1 irq_en; [7:4] wait_cnt.
  - 9 STATUS: bit0 wp_fault (write 1 clears); bit1 = FSM in DMA_ACC (read only).
- Translation, latched at access start:
  - If map_en AND WIN_MASK[s] with s = cpu_addr[15:13]: ext_addr = {PAGEs page, cpu_addr[12:0]}.
  - Otherwise ext_addr = zero-extended cpu_addr.
  - DMA addresses are always zero-extended.
- FSM states: IDLE, CPU_ACC, DMA_ACC, DONE.
  - IDLE, grant decision:
    - dma_req only -> DMA.
    - cpu_req only -> CPU.
    - Both -> DMA if burst_cnt < DMA_MAX_BURST, else CPU.
    - A DMA grant increments burst_cnt (saturating); a CPU grant clears it.
    - burst_cnt also clears in IDLE when cpu_req=0.
  - On grant: latch address, rw, wdata and cnt=wait_cnt, then enter the ACC state.
  - ACC: ext_cs=1 and address stable for wait_cnt+1 cycles.
    - Read: ext_oe_n=0.
    - Write: ext_dq_oe=1, and ext_we_n=0 on all ACC cycles except the first (with wait_cnt=0, the single cycle).
    - Last ACC cycle: capture ext_dq_in into cpu_rdata or dma_rdata; go to DONE.
  - DONE, one cycle:
    - Pins idle.
    - CPU access: cpu_hold=0 this cycle.
    - DMA access: dma_ack=1 this cycle.
    - Next state IDLE; cpu_req is not sampled in DONE.
- cpu_hold = cpu_req AND NOT (state==DONE AND last grant was CPU).
- Latency: a request sampled in IDLE at cycle 0 completes in DONE at cycle wait_cnt+2.
- Write-protected CPU write (mapped slot with WP=1):
  - Full access timing, but ext_we_n stays 1 and ext_dq_oe=0.
  - wp_fault set in DONE.
  - If a clear-write to STATUS lands in the same cycle, set wins.
- Register changes during an in-flight access affect only later accesses.
- A write to wait_cnt takes effect at the next grant.

Decomposition:
- extbus_pkg:
  - FSM state enum.
  - Register offsets REG_PAGE0..7, REG_CTRL, REG_STATUS.
  - CTRL/STATUS bit positions.
  - Page register width helper.
- One sub-module, extbus_map: page/CTRL/STATUS register file plus combinational translation and WP lookup.
- Arbitration FSM and pin drive live in the top-level extbus_ctrl.

Test Plan:
- Reset defaults, wait_cnt=1, CPU read $2000 (unmapped) -> ext_addr=19'h02000, ext_oe_n low cycles 1-2, cpu_hold high cycles 0-2 and low cycle 3, cpu_rdata = SRAM byte.
- PAGE6=8'h05, map_en=1, CPU write $C123=8'hA5 -> ext_addr=19'h0A123, ext_we_n low only in cycle 2, ext_dq_out=8'hA5.
- PAGE5=8'h83, map_en=1, irq_en=1, CPU write $A000 -> ext_we_n stays 1, STATUS=1, irq=1; STATUS write 8'h01 -> irq=0.
- dma_req and cpu_req held together with DMA_MAX_BURST=4 -> grant order D,D,D,D,C,D..., one dma_ack per DMA access, the CPU completes within 5 accesses.
- wait_cnt set to 0 -> back-to-back DMA reads yield dma_ack every 3 cycles.
- rst asserted mid-CPU write -> ext_we_n=1, ext_cs=0 immediately, FSM in IDLE, page regs 0.
